// File: rtl/pwm_duty_seq.sv
// Period-synchronous PWM duty-cycle sequencer: plays a table of per-channel compare values,
// one entry per max(hold,1) PWM periods. Define PWM_SEQ_LOOP_EN to add the loop_i wrap-around mode.
module pwm_duty_seq #(
    parameter int CH    = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int HW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [CH*DW-1:0] wr_data_i,
    input  logic [AW:0]      len_i,
    input  logic [HW-1:0]    hold_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             prd_i,
`ifdef PWM_SEQ_LOOP_EN
    input  logic             loop_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [AW-1:0]    idx_o,
    output logic [CH*DW-1:0] duty_o,
    output logic             duty_upd_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CH*DW-1:0] table_q [DEPTH];
    logic [CH*DW-1:0] table_d [DEPTH];
    logic [AW:0]      len_q, len_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [HW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [CH*DW-1:0] duty_q, duty_d;
    logic             upd_q, upd_d;
    logic             err_q, err_d;
    logic             loop_en;
    logic             len_ok;
    logic             last_entry;
    logic [AW-1:0]    idx_next;

`ifdef PWM_SEQ_LOOP_EN
    logic loop_q, loop_d;
    assign loop_en = loop_q;
`else
    assign loop_en = 1'b0;
`endif

    assign busy_o     = (state_q == S_WAIT) || (state_q == S_HOLD);
    assign done_o     = (state_q == S_DONE);
    assign err_o      = err_q;
    assign idx_o      = idx_q;
    assign duty_o     = duty_q;
    assign duty_upd_o = upd_q;

    assign len_ok     = (len_i != '0) && (len_i <= (AW+1)'(DEPTH));
    assign last_entry = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));
    assign idx_next   = idx_q + AW'(1);

    // Table writes are only honoured while no sequence is armed or running.
    always_comb begin
        table_d = table_q;
        if (wr_en_i && !busy_o) begin
            table_d[wr_addr_i] = wr_data_i;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        len_d   = len_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        duty_d  = duty_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
`ifdef PWM_SEQ_LOOP_EN
        loop_d  = loop_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_ok) begin
                        state_d = S_WAIT;
                        idx_d   = '0;
                        len_d   = len_i;
                        hold_d  = (hold_i == '0) ? HW'(1) : hold_i;
`ifdef PWM_SEQ_LOOP_EN
                        loop_d  = loop_i;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (prd_i) begin
                    duty_d  = table_q[0];
                    upd_d   = 1'b1;
                    cnt_d   = hold_q;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (prd_i) begin
                    if (cnt_q > HW'(1)) begin
                        cnt_d = cnt_q - HW'(1);
                    end else if (!last_entry) begin
                        idx_d  = idx_next;
                        duty_d = table_q[idx_next];
                        upd_d  = 1'b1;
                        cnt_d  = hold_q;
                    end else if (loop_en) begin
                        idx_d  = '0;
                        duty_d = table_q[0];
                        upd_d  = 1'b1;
                        cnt_d  = hold_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Stop overrides everything, including a same-cycle start; outputs are frozen.
        if (stop_i) begin
            state_d = S_IDLE;
            idx_d   = idx_q;
            duty_d  = duty_q;
            upd_d   = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            duty_q  <= '0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef PWM_SEQ_LOOP_EN
            loop_q  <= 1'b0;
`endif
            // NOTE: the table is a flop array that must read back as zero after reset,
            // so it is cleared here rather than left to power-up contents.
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            duty_q  <= duty_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
`ifdef PWM_SEQ_LOOP_EN
            loop_q  <= loop_d;
`endif
            table_q <= table_d;
        end
    end

endmodule

// File: tb/tb_pwm_duty_seq.sv
// Scoreboard bench for pwm_duty_seq: stimulus pushes expected output events, a negedge
// monitor pops and compares each duty_upd/done/err event including the cycle it appears.
module tb_pwm_duty_seq;

    localparam int CH = 4, DW = 16, DEPTH = 16, HW = 8, AW = 4;

    logic             clk_i = 1'b0;
    logic             rst_n_i = 1'b0;
    logic             wr_en_i = 1'b0;
    logic [AW-1:0]    wr_addr_i = '0;
    logic [CH*DW-1:0] wr_data_i = '0;
    logic [AW:0]      len_i = '0;
    logic [HW-1:0]    hold_i = '0;
    logic             start_i = 1'b0;
    logic             stop_i = 1'b0;
    logic             prd_i = 1'b0;
`ifdef PWM_SEQ_LOOP_EN
    logic             loop_i = 1'b0;
`endif
    logic             busy_o, done_o, err_o, duty_upd_o;
    logic [AW-1:0]    idx_o;
    logic [CH*DW-1:0] duty_o;

    pwm_duty_seq #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .HW(HW)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .len_i      (len_i),
        .hold_i     (hold_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .prd_i      (prd_i),
`ifdef PWM_SEQ_LOOP_EN
        .loop_i     (loop_i),
`endif
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .idx_o      (idx_o),
        .duty_o     (duty_o),
        .duty_upd_o (duty_upd_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        upd;
        logic        done;
        logic        err;
        logic        busy;
        logic [63:0] duty;
        logic [3:0]  idx;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [63:0] mk(input logic [15:0] c0);
        return {c0 + 16'h0300, c0 + 16'h0200, c0 + 16'h0100, c0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected event lands one cycle after the inputs driven in the current cycle.
    task automatic expect_ev(input logic upd, input logic done, input logic err,
                             input logic [63:0] duty, input logic [3:0] idx);
        exp_t e;
        e.upd  = upd;
        e.done = done;
        e.err  = err;
        e.busy = upd;
        e.duty = duty;
        e.idx  = idx;
        e.cyc  = cyc + 1;
        q.push_back(e);
    endtask

    always @(negedge clk_i) begin
        if (rst_n_i && (duty_upd_o || done_o || err_o)) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: cyc=%0d upd=%b done=%b err=%b duty=%h idx=%0d expected no event",
                         cyc, duty_upd_o, done_o, err_o, duty_o, idx_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (duty_upd_o !== e.upd || done_o !== e.done || err_o !== e.err ||
                    busy_o !== e.busy || duty_o !== e.duty || idx_o !== e.idx || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL event: got cyc=%0d upd=%b done=%b err=%b busy=%b duty=%h idx=%0d expected cyc=%0d upd=%b done=%b err=%b busy=%b duty=%h idx=%0d",
                             cyc, duty_upd_o, done_o, err_o, busy_o, duty_o, idx_o,
                             e.cyc, e.upd, e.done, e.err, e.busy, e.duty, e.idx);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        wr_en_i = 1'b0;
        start_i = 1'b0;
        stop_i  = 1'b0;
        prd_i   = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [63:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        tick();
    endtask

    task automatic prd_pulse();
        prd_i = 1'b1;
        tick();
        repeat (9) tick();
    endtask

    task automatic start_seq(input logic [AW:0] len, input logic [HW-1:0] hold);
        len_i   = len;
        hold_i  = hold;
        start_i = 1'b1;
        tick();
    endtask

    initial begin
        #12;
        check("reset_duty", duty_o, 64'h0);
        check("reset_busy", {63'h0, busy_o}, 64'h0);
        check("reset_idx", {60'h0, idx_o}, 64'h0);
        check("reset_flags", {61'h0, done_o, err_o, duty_upd_o}, 64'h0);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        tick();

        // Basic sequence: len=3, hold=2.
        wr(0, mk(16'h10));
        wr(1, mk(16'h20));
        wr(2, mk(16'h30));
        start_seq(3, 2);
        check("start_busy", {63'h0, busy_o}, 64'h1);
        tick();
        expect_ev(1, 0, 0, mk(16'h10), 0); prd_pulse();
        prd_pulse();
        expect_ev(1, 0, 0, mk(16'h20), 1); prd_pulse();
        prd_pulse();
        expect_ev(1, 0, 0, mk(16'h30), 2); prd_pulse();
        prd_pulse();
        expect_ev(0, 1, 0, mk(16'h30), 2); prd_pulse();
        check("basic_idle_after_done", {63'h0, busy_o}, 64'h0);
        check("basic_duty_kept", duty_o, mk(16'h30));

        // Rejected starts.
        expect_ev(0, 0, 1, mk(16'h30), 2); start_seq(0, 1);
        check("rej0_busy", {63'h0, busy_o}, 64'h0);
        tick();
        expect_ev(0, 0, 1, mk(16'h30), 2); start_seq(5'(DEPTH + 1), 1);
        check("rej17_busy", {63'h0, busy_o}, 64'h0);
        check("rej_duty_kept", duty_o, mk(16'h30));
        tick();

        // Hold of zero; a prd in the start cycle is not counted.
        len_i = 2; hold_i = 0; start_i = 1'b1; prd_i = 1'b1;
        tick();
        repeat (9) tick();
        check("hold0_busy", {63'h0, busy_o}, 64'h1);
        expect_ev(1, 0, 0, mk(16'h10), 0); prd_pulse();
        expect_ev(1, 0, 0, mk(16'h20), 1); prd_pulse();
        expect_ev(0, 1, 0, mk(16'h20), 1); prd_pulse();

        // Stop with simultaneous start during HOLD; busy write must be dropped.
        start_seq(3, 3);
        expect_ev(1, 0, 0, mk(16'h10), 0); prd_pulse();
        wr(0, 64'hFF);
        prd_pulse();
        stop_i = 1'b1; start_i = 1'b1;
        tick();
        check("stop_busy", {63'h0, busy_o}, 64'h0);
        check("stop_idx", {60'h0, idx_o}, 64'h0);
        check("stop_duty", duty_o, mk(16'h10));
        repeat (5) tick();
        check("stop_start_discarded", {63'h0, busy_o}, 64'h0);
        start_seq(1, 1);
        expect_ev(1, 0, 0, mk(16'h10), 0); prd_pulse();
        expect_ev(0, 1, 0, mk(16'h10), 0); prd_pulse();
        wr(0, 64'hFF);
        start_seq(1, 1);
        expect_ev(1, 0, 0, 64'hFF, 0); prd_pulse();
        expect_ev(0, 1, 0, 64'hFF, 0); prd_pulse();

`ifdef PWM_SEQ_LOOP_EN
        // Loop: len=2 alternates indefinitely until stop.
        loop_i = 1'b1;
        start_seq(2, 1);
        loop_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) expect_ev(1, 0, 0, 64'hFF, 0);
            else            expect_ev(1, 0, 0, mk(16'h20), 1);
            prd_pulse();
        end
        check("loop_still_busy", {63'h0, busy_o}, 64'h1);
        stop_i = 1'b1;
        tick();
        check("loop_stop_busy", {63'h0, busy_o}, 64'h0);
        tick();
`endif

        // Reset mid-run clears outputs immediately and wipes the table.
        start_seq(2, 4);
        expect_ev(1, 0, 0, 64'hFF, 0); prd_pulse();
        prd_pulse();
        rst_n_i = 1'b0;
        #1;
        check("rst_duty", duty_o, 64'h0);
        check("rst_busy", {63'h0, busy_o}, 64'h0);
        check("rst_idx", {60'h0, idx_o}, 64'h0);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        tick();
        start_seq(1, 1);
        expect_ev(1, 0, 0, 64'h0, 0); prd_pulse();
        expect_ev(0, 1, 0, 64'h0, 0); prd_pulse();

        repeat (5) tick();
        check("queue_drained", 64'(q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_duty_seq.md
# pwm_duty_seq

Period-synchronous duty-cycle sequencer for the PWM timer. It holds a small table of per-channel compare (CRx) values and steps through it one entry at a time, holding each entry for a programmable number of PWM periods. It sits between the system-side configuration logic and the PWM compare registers. Every duty update is aligned to the PWM period-end strobe, so no glitched or partial period is ever produced.

## Interface
- `CH`, 4, number of PWM channels per table entry
- `DW`, 16, compare value width per channel (matches the PWM CRx width)
- `DEPTH`, 16, number of table entries; must be a power of two and ≥2
- `HW`, 8, width of the hold-period count
- `AW`, `$clog2(DEPTH)`, table index width (derived)

Ports:
- `clk_i` input 1: single clock, same domain as the PWM counter strobe
- `rst_n_i` input 1: asynchronous active-low reset
- `wr_en_i` input 1: table write strobe
- `wr_addr_i` input AW: table write index
- `wr_data_i` input CH*DW: entry data; channel n occupies `[n*DW +: DW]`
- `len_i` input AW+1: number of entries to play; valid range 1..DEPTH
- `hold_i` input HW: periods per entry; 0 is treated as 1
- `start_i` input 1: start request, single-cycle pulse
- `stop_i` input 1: abort request
- `prd_i` input 1: PWM period-end strobe, one cycle wide, spacing ≥2 cycles
- `busy_o` output 1: sequence armed or running
- `done_o` output 1: one-cycle pulse when a sequence completes normally
- `err_o` output 1: one-cycle pulse when a start is rejected
- `idx_o` output AW: index of the entry currently applied
- `duty_o` output CH*DW: current compare values driven to the PWM
- `duty_upd_o` output 1: one-cycle pulse when `duty_o` has just changed

## Operation
- **Table storage:** the table is a flop array.
  - A write lands when `wr_en_i=1` and `busy_o=0`.
  - A write attempted while `busy_o=1` is silently dropped.
- **Start sampling:** `len_i`, `hold_i` (and `loop_i` when configured) are latched on an accepted `start_i`.
- **IDLE state:** `busy_o=0`.
  - `start_i` with 1≤`len_i`≤DEPTH moves to WAIT; `idx` is cleared.
  - `start_i` with `len_i`=0 or `len_i`>DEPTH: `err_o` pulses, the block stays in IDLE, and outputs are unchanged.
- **WAIT state:** `busy_o=1`.
  - On `prd_i`: `duty_o`←table[0], `duty_upd_o` pulses, the hold counter is loaded with max(hold,1), and the block moves to HOLD.
- **HOLD state:** `busy_o=1`. On each `prd_i`:
  - If the hold counter is >1, it decrements.
  - Otherwise the block advances:
    - If `idx`<len-1: `idx`++, `duty_o`←table[idx], `duty_upd_o` pulses, and the hold counter reloads.
    - If `idx`=len-1 and looping is enabled: `idx`←0, table[0] is applied, `duty_upd_o` pulses.
    - If `idx`=len-1 and looping is not enabled: move to DONE; `duty_o` is unchanged.
- **DONE state:** lasts one cycle with `done_o=1` and `busy_o=0`, then returns to IDLE.
- **Stop:** `stop_i` in any state goes to IDLE on the next edge.
  - `duty_o` and `idx_o` retain their values.
  - There is no `done_o` and no `duty_upd_o`.
  - If `stop_i` and `start_i` arrive together, stop wins and the start is discarded.
- **Busy restarts:** `start_i` while `busy_o=1` is ignored, with no error.
- **Output persistence:** `duty_o` keeps the last applied entry after DONE or stop until the next sequence applies a new entry.

## Timing
- **Reset:** all outputs are 0, the state is IDLE, and all table entries are 0.
- **Start latency:** `start_i` at cycle T gives `busy_o=1` at T+1. A `prd_i` at T is not counted.
- **Update latency:** `prd_i` at cycle T produces the new `duty_o` and the `duty_upd_o` pulse at T+1, registered together.
- **Hold length:** entry k is held for exactly max(hold,1) periods. Total periods from the first update to DONE = len×max(hold,1).
- **Completion:** `done_o` is asserted at T+1 after the final `prd_i`. `busy_o` falls in the same cycle.
- **Write collisions:** a table write in the same cycle as an accepted start is still committed, because `busy_o` is still 0.
- **Reset mid-run:** the asynchronous reset drives every output to its reset value immediately. The sequence is lost.

## Configuration
- Macro: `PWM_SEQ_LOOP_EN`.
- **Defined:**
  - Adds input `loop_i` (1 bit), sampled on an accepted start.
  - With `loop_i=1`, the table wraps from len-1 back to 0 indefinitely, never reaches DONE, and ends only via `stop_i` or reset.
- **Undefined:**
  - The `loop_i` port is absent.
  - Every sequence plays once and ends in DONE.

## Test plan
- **Basic sequence:** write ch0 values 0x10/0x20/0x30 at indices 0..2; set len=3, hold=2; pulse start; `prd_i` every 10 cycles.
  - Required: `duty_upd_o` one cycle after prd #1, #3 and #5, with ch0 = 0x10, 0x20 and 0x30.
  - Required: `done_o` one cycle after prd #7; `duty_o` stays 0x30.
- **Rejected starts:** start with len=0, then with len=DEPTH+1.
  - Required: `err_o` pulses once each time; `busy_o` stays 0; `duty_o` is unchanged.
- **Hold of zero:** set hold=0, len=2.
  - Required: a `duty_upd_o` after each of prd #1 and #2, then `done_o` after prd #3.
- **Stop and busy writes:** during HOLD, raise `stop_i` together with `start_i`, then write table[0]=0xFF.
  - Required: IDLE next cycle, no `done_o`, `duty_o` retained.
  - Required: writing table[0]=0xFF during the earlier busy phase had no effect.
- **Loop (with `PWM_SEQ_LOOP_EN`):** len=2, hold=1, `loop_i=1`.
  - Required: ch0 alternates entry0/entry1 on every prd for 6 periods with no `done_o`.
  - Required: `stop_i` ends the sequence with `busy_o=0`.
- **Reset mid-run:** assert `rst_n_i` low while in HOLD.
  - Required: `duty_o`, `busy_o` and `idx_o` are all 0 immediately.
  - Required: after release, a restart with len=1 applies 0, because the table was cleared.
